// File: rtl/poly_output_stream_drain.sv
// Purpose : drains the head slot of the output poly FIFO onto a valid/ready line stream.
// Latency : 3 cycles from (enable & !fifo_empty) in IDLE to the first m_valid; then 1 line/cycle.
// Backpr. : m_ready low stalls the stream; RAM issues are credit-gated so the buffer never overflows.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   enable, fifo_empty        start condition, sampled only in IDLE
//   fifo_rd_finish            1 when idle or releasing the slot (DONE), 0 while reading it
//   fifo_addrA/B, fifo_dA/B   dual-port RAM read (even lines on A, odd on B), data 1 cycle later
//   m_data/m_valid/m_ready    output line stream, m_last on line NUM_LINES-1
//   busy, poly_count          status: not IDLE, number of fully drained polys (wraps)
module poly_output_stream_drain #(
    parameter int BIT_WIDTH  = 16,
    parameter int LINE_SIZE  = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int LINE_W     = BIT_WIDTH * LINE_SIZE,
    parameter int ADDR_W     = ADDR_WIDTH,
    parameter int BUF_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_finish,
    output logic [ADDR_W-1:0] fifo_addrA,
    output logic [ADDR_W-1:0] fifo_addrB,
    input  logic [LINE_W-1:0] fifo_dA,
    input  logic [LINE_W-1:0] fifo_dB,
    output logic [LINE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       poly_count
);

    localparam int NUM_LINES = 2 ** ADDR_W;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = PTR_W + 1;
    localparam int NEED_W    = OCC_W + 2;

    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_LINES / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(NUM_LINES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              inflight_q, inflight_d;
    logic [15:0]       poly_count_q, poly_count_d;

    logic [LINE_W-1:0] buf_q [BUF_DEPTH];
    logic [LINE_W-1:0] buf_d [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ADDR_W-1:0] beat_q, beat_d;

    logic              issue;
    logic              pop;
    logic              can_issue;
    logic [NEED_W-1:0] need;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [PTR_W-1:0]  wr_ptr_p1;

    // Stream side: buffer head is presented directly; beat counter gives m_last
    // without storing address bits alongside the data.
    assign m_valid = (occ_q != '0);
    assign m_data  = buf_q[rd_ptr_q];
    assign m_last  = m_valid && (beat_q == LAST_LINE);
    assign pop     = m_valid && m_ready;

    // Room must remain for the pair about to be issued plus any pair still in
    // the RAM pipeline; occupancy is taken before this cycle's pop.
    always_comb begin
        need      = NEED_W'(occ_q) + (inflight_q ? NEED_W'(4) : NEED_W'(2));
        can_issue = (need <= NEED_W'(BUF_DEPTH));
    end

    // Control FSM and issue addressing.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        poly_count_d = poly_count_q;
        issue        = 1'b0;
        addr_a       = '0;
        addr_b       = '0;
        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = S_READ;
                    k_d     = '0;
                end
            end
            S_READ: begin
                addr_a = ADDR_W'({k_q, 1'b0});
                addr_b = addr_a | ADDR_W'(1);
                if (can_issue) begin
                    issue = 1'b1;
                    k_d   = k_q + ADDR_W'(1);
                    if (k_q == LAST_PAIR) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                poly_count_d = poly_count_q + 16'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Return path: both RAM lines land in the same cycle, A before B so the
    // buffer stays in address order.
    always_comb begin
        wr_ptr_p1  = wr_ptr_q + PTR_W'(1);
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_d     = beat_q;
        inflight_d = issue;
        occ_d      = occ_q + (inflight_q ? OCC_W'(2) : OCC_W'(0))
                           - (pop ? OCC_W'(1) : OCC_W'(0));
        if (inflight_q) begin
            buf_d[wr_ptr_q]  = fifo_dA;
            buf_d[wr_ptr_p1] = fifo_dB;
            wr_ptr_d         = wr_ptr_q + PTR_W'(2);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            // wraps to 0 naturally after the last line of a poly
            beat_d   = beat_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            inflight_q   <= 1'b0;
            poly_count_q <= '0;
            buf_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            inflight_q   <= inflight_d;
            poly_count_q <= poly_count_d;
            buf_q        <= buf_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            beat_q       <= beat_d;
        end
    end

    assign fifo_rd_finish = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);
    assign fifo_addrA     = addr_a;
    assign fifo_addrB     = addr_b;
    assign poly_count     = poly_count_q;

endmodule

// File: doc/poly_output_stream_drain.md
# poly_output_stream_drain

Drain engine between the global output poly FIFO and the host DMA path. Whenever the FIFO holds a completed polynomial, it reads every line of the head slot through both RAM ports, two lines per issue. It buffers the returned data against back-pressure and emits the lines in address order on a valid/ready stream, with `m_last` on the final line. After the last line is accepted, it returns the slot to the FIFO by raising `fifo_rd_finish`.

## Interface
Parameters:
- `LINE_W`, default `BIT_WIDTH*LINE_SIZE`: width of one poly RAM line.
- `ADDR_W`, default `ADDR_WIDTH`: line address width. A poly is `NUM_LINES = 2**ADDR_W` lines, and `NUM_LINES` is even.
- `BUF_DEPTH`, default 4: prefetch buffer depth in lines. Must be a power of 2 and at least 4.

Ports:
- `clk`: input, 1 bit. Clock.
- `rstn`: input, 1 bit. Reset, synchronous, active-low.
- `enable`: input, 1 bit. Allows a new poly transfer to start.
- `fifo_empty`: input, 1 bit. Empty flag of the output poly FIFO.
- `fifo_rd_finish`: output, 1 bit. High means idle or releasing a slot; low means reading the head slot.
- `fifo_addrA`: output, `ADDR_W` bits. Read address on port A (even lines).
- `fifo_addrB`: output, `ADDR_W` bits. Read address on port B (odd lines).
- `fifo_dA`: input, `LINE_W` bits. Port A read data, valid 1 cycle after the address.
- `fifo_dB`: input, `LINE_W` bits. Port B read data, valid 1 cycle after the address.
- `m_data`: output, `LINE_W` bits. Stream data.
- `m_valid`: output, 1 bit. Stream valid.
- `m_ready`: input, 1 bit. Stream ready.
- `m_last`: output, 1 bit. Marks line `NUM_LINES-1` of a poly.
- `busy`: output, 1 bit. High in any state except IDLE.
- `poly_count`: output, 16 bits. Number of polys fully drained; wraps modulo 2^16.

## Operation
The block has four states: IDLE, READ, DRAIN and DONE.
- **IDLE**
  - `fifo_rd_finish` is 1.
  - On `enable & !fifo_empty`, go to READ. The pair index k is cleared to 0.
- **READ**
  - `fifo_rd_finish` is 0.
  - An issue is the rule: `fifo_addrA = 2k`, `fifo_addrB = 2k+1`, `issue = 1`.
  - Issue fires when `BUF_DEPTH - occupancy - 2*inflight >= 2`, where `inflight` is the 1-bit flag for an issue made last cycle.
  - Otherwise hold the addresses and set `issue = 0`.
  - k increments on each issue.
  - The issue with `k = NUM_LINES/2-1` moves the block to DRAIN.
- **Return path**
  - When `inflight` is 1, push `fifo_dA` and then `fifo_dB` into the circular buffer in the same cycle (two writes).
  - The buffer pops one line per `m_valid & m_ready`.
  - `m_valid` equals "buffer not empty"; `m_data` is the buffer head.
- **`m_last`**: high when the head line's address is `NUM_LINES-1`. Track it with a beat counter, not stored address bits.
- **DRAIN**
  - `fifo_rd_finish` is 0 and no issues are made.
  - Go to DONE in the cycle the last beat is accepted (`m_valid & m_ready & m_last`).
- **DONE**
  - `fifo_rd_finish` is 1 for exactly 1 cycle, which advances the FIFO read pointer.
  - `poly_count` increments.
  - Next state is IDLE.
- **`enable` deasserted mid-poly**: ignored. The current poly always completes. `enable` is sampled only in IDLE.
- **`fifo_empty` in READ/DRAIN**: ignored. Under legal operation it is 0 there.
- **Simultaneous push of 2 and pop of 1**: occupancy changes by +1. Occupancy never exceeds `BUF_DEPTH`, which the credit rule guarantees.
- **Widths**
  - occupancy is `$clog2(BUF_DEPTH)+1` bits.
  - The beat counter is `ADDR_W` bits and wraps to 0 after `m_last`.
- **Addresses outside READ**: `fifo_addrA` and `fifo_addrB` are 0.

## Timing
- **Reset values**: state IDLE, `fifo_rd_finish` 1, addresses 0, `m_valid` 0, `m_data` 0, `m_last` 0, `busy` 0, `poly_count` 0. The buffer, k, `inflight` and the beat counter are all cleared.
- **Reset mid-transfer**: all of the above are restored the next cycle. Partially drained data is discarded.
- **Start latency**:
  - The cycle `enable & !fifo_empty` is seen in IDLE: transition only.
  - First READ cycle: issue pair 0.
  - Next cycle: lines 0 and 1 written.
  - Following cycle: `m_valid` rises with line 0.
  - That is 3 cycles from the start condition to the first `m_valid`.
- **Throughput**:
  - Issue 2 lines/cycle, drain 1 line/cycle. The stream is the bottleneck.
  - With `m_ready` held high, `m_valid` is continuous from line 0 to `NUM_LINES-1` with no bubbles.
- **End of poly**:
  - The last beat is accepted at cycle T.
  - DONE is at T+1 with `fifo_rd_finish` = 1.
  - IDLE is at T+2, with `fifo_empty` re-evaluated there.
  - Back-to-back polys therefore have a minimum gap of 2 cycles without `m_valid` between `m_last` and the next line 0, plus the 3-cycle start latency.
- **Data hold**: `m_data`, `m_valid` and `m_last` stay stable while `m_valid & !m_ready`.

## Test plan
- **Single poly, continuous ready**: `ADDR_W`=3, FIFO slot filled with line i = i+1, `m_ready` held 1. Expect 8 beats of data 1..8 in consecutive cycles, `m_last` only on data 8, then `fifo_rd_finish` high for 1 cycle and `poly_count` = 1.
- **Back-pressure**: `m_ready` toggling 1,0,0,1 repeatedly. Expect no lost or duplicated line, occupancy never above 4, and stable `m_data` while stalled.
- **Empty FIFO**: `enable`=1 with `fifo_empty`=1 for 20 cycles. Expect `fifo_rd_finish` held 1, no `m_valid`, and `busy` 0.
- **Two polys back-to-back**: FIFO holds 2 slots. Expect 16 beats total, 2 DONE pulses, `poly_count` = 2, and a gap of exactly 4 cycles between beat 8 and beat 9.
- **`enable` dropped mid-poly**: `enable` goes to 0 after beat 3. Expect the poly to complete, then the block to stay in IDLE with the remaining slot untouched.
- **Reset mid-transfer**: `rstn` low during beat 5. Expect all outputs at their reset values the next cycle and `poly_count` = 0.
